// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHK state only exists when LOADER_CHKSUM_EN is defined.
package imem_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef LOADER_CHKSUM_EN
    CHK   = 3'd4,
`endif
    DONE  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from a byte stream; word_valid
// pulses for one cycle after the fourth byte of a word has been taken.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        last_byte
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] count_reg;
  logic [31:0]   word_reg;
  logic          valid_reg;

  assign last_byte  = (count_reg == CW'(WORD_BYTES - 1));
  assign word_out   = word_reg;
  assign word_valid = valid_reg;

  // Shifting in from the top leaves byte 0 in [7:0] once all four arrive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (clear) begin
        count_reg <= '0;
        word_reg  <= '0;
      end else if (byte_valid) begin
        word_reg  <= {byte_in, word_reg[31:8]};
        count_reg <= count_reg + CW'(1);
        valid_reg <= last_byte;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding
// the CPU in reset. Optional trailing XOR checksum under LOADER_CHKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          busy
`ifdef LOADER_CHKSUM_EN
  ,
  output logic          chk_err
`endif
);

  // One extra bit so a count of exactly DEPTH is representable.
  localparam int IW = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);

  loader_state_t state_reg, state_next;
  logic [IW-1:0] word_index_reg;
  logic [IW-1:0] n_reg;
  logic [IW-1:0] len_value;
  logic [AW-1:0] mem_addr_reg;

  logic          xfer;
  logic          start_load;
  logic          packer_valid;
  logic          last_byte;
  logic          word_valid;
  logic [31:0]   word_out;

  assign xfer         = rx_valid && rx_ready;
  assign start_load   = (state_reg == IDLE) && start;
  assign packer_valid = (state_reg == DATA) && rx_valid;

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_load),
    .byte_in    (rx_data),
    .byte_valid (packer_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .last_byte  (last_byte)
  );

  always_comb begin
    len_value = IW'(rx_data);
    if (rx_data == 8'd0 || int'(rx_data) > DEPTH) begin
      len_value = DEPTH_W;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = LEN;
      LEN:   if (xfer) state_next = DATA;
      DATA:  if (xfer && last_byte) state_next = WRITE;
      WRITE: begin
        if (word_index_reg + IW'(1) < n_reg) begin
          state_next = DATA;
        end else begin
`ifdef LOADER_CHKSUM_EN
          state_next = CHK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHKSUM_EN
      CHK:   if (xfer) state_next = DONE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    case (state_reg)
      LEN, DATA: rx_ready = 1'b1;
`ifdef LOADER_CHKSUM_EN
      CHK:       rx_ready = 1'b1;
`endif
      default:   rx_ready = 1'b0;
    endcase
  end

  // The address is captured with the last byte so it is stable for the WRITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_index_reg <= '0;
      n_reg          <= '0;
      mem_addr_reg   <= '0;
    end else begin
      if (start_load) begin
        word_index_reg <= '0;
      end
      if (state_reg == LEN && xfer) begin
        n_reg <= len_value;
      end
      if (state_reg == DATA && xfer && last_byte) begin
        mem_addr_reg <= AW'({word_index_reg, 2'b00});
      end
      if (state_reg == WRITE) begin
        word_index_reg <= word_index_reg + IW'(1);
      end
    end
  end

  assign mem_we    = word_valid;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = word_out;
  assign busy      = (state_reg != IDLE);
  assign cpu_hold  = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

`ifdef LOADER_CHKSUM_EN
  logic [7:0] xor_reg;
  logic       chk_err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xor_reg     <= '0;
      chk_err_reg <= 1'b0;
    end else if (start_load) begin
      xor_reg     <= '0;
      chk_err_reg <= 1'b0;
    end else begin
      if (state_reg == DATA && xfer) begin
        xor_reg <= xor_reg ^ rx_data;
      end
      if (state_reg == CHK && xfer) begin
        chk_err_reg <= (rx_data != xor_reg);
      end
    end
  end

  assign chk_err = chk_err_reg;
`endif

endmodule
